// File: rtl/i2c_reg_preload_seq.sv
// i2c_reg_preload_seq: streams a shadow table of register values into the
// preload port of i2c_slave_handler, after reset and on request.
//   clk, rst_n                  clock, asynchronous active-low reset
//   reload_req                  pulse: request a (re)load sequence
//   hold                        pause emission while the I2C bus is busy
//   cfg_we, cfg_idx, cfg_data   runtime write of one shadow-table entry
//   preload_en/addr/data        one-cycle register write strobe to the slave
//   busy                        sequence in progress (LOAD or GAP)
//   done_pulse                  one cycle after the last entry is emitted
//   loaded                      a full sequence completed since the last start
//   load_count                  completed sequences, saturating at 8'hFF
module i2c_reg_preload_seq #(
    parameter int NUM_REGS    = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int BASE_ADDR   = 0,
    parameter     INIT_VALUES = 32'hDDCCBBAA,
    parameter bit AUTO_START  = 1'b1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          reload_req,
    input  logic                          hold,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_REGS):0]     cfg_idx,
    input  logic [DATA_W-1:0]             cfg_data,
    output logic                          preload_en,
    output logic [ADDR_W-1:0]             preload_addr,
    output logic [DATA_W-1:0]             preload_data,
    output logic                          busy,
    output logic                          done_pulse,
    output logic                          loaded,
    output logic [7:0]                    load_count
);
    localparam int IW = $clog2(NUM_REGS) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 2);

    if (NUM_REGS < 1) begin : g_chk_num
        $error("NUM_REGS must be at least 1");
    end
    if ((longint'(BASE_ADDR) + NUM_REGS - 1) >= (64'd1 << ADDR_W)) begin : g_chk_addr
        $error("BASE_ADDR+NUM_REGS-1 does not fit in ADDR_W");
    end
    if ($bits(INIT_VALUES) < NUM_REGS * DATA_W) begin : g_chk_init
        $error("INIT_VALUES narrower than NUM_REGS*DATA_W");
    end

    typedef enum logic [1:0] {IDLE, LOAD, GAP, DONE} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [GW-1:0]     gap, gap_n;
    logic              start_pending, start_pending_n;
    logic              fin, fin_n;
    logic              en_n, loaded_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n, rd;
    logic [7:0]        cnt_n;
    logic [DATA_W-1:0] tbl [NUM_REGS];

    always_comb begin
        rd = tbl[0];
        for (int i = 1; i < NUM_REGS; i++)
            if (idx == IW'(i)) rd = tbl[i];
        state_n         = state;
        idx_n           = idx;
        gap_n           = gap;
        en_n            = 1'b0;
        addr_n          = preload_addr;
        data_n          = preload_data;
        fin_n           = 1'b0;
        start_pending_n = start_pending | reload_req;
        loaded_n        = fin ? 1'b1 : loaded;
        cnt_n           = fin ? load_count + 8'(load_count != 8'hFF) : load_count;
        case (state)
            IDLE, DONE: begin
                // A start on the same edge as a completion wins: loaded tracks the new run.
                if (start_pending_n) begin
                    state_n         = LOAD;
                    idx_n           = '0;
                    loaded_n        = 1'b0;
                    start_pending_n = 1'b0;
                end
            end
            LOAD: begin
                if (!hold) begin
                    en_n   = 1'b1;
                    addr_n = ADDR_W'(BASE_ADDR + int'(idx));
                    data_n = rd;
                    if (idx == IW'(NUM_REGS - 1)) begin
                        state_n = DONE;
                        fin_n   = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                            gap_n   = GW'(GAP_CYCLES - 1);
                        end
                    end
                end
            end
            GAP: begin
                if (!hold) begin
                    if (gap == '0) state_n = LOAD;
                    else gap_n = gap - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            gap           <= '0;
            start_pending <= AUTO_START;
            fin           <= 1'b0;
            preload_en    <= 1'b0;
            preload_addr  <= '0;
            preload_data  <= '0;
            busy          <= 1'b0;
            done_pulse    <= 1'b0;
            loaded        <= 1'b0;
            load_count    <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                tbl[i] <= INIT_VALUES[i*DATA_W +: DATA_W];
        end else begin
            idx           <= idx_n;
            gap           <= gap_n;
            start_pending <= start_pending_n;
            fin           <= fin_n;
            preload_en    <= en_n;
            preload_addr  <= addr_n;
            preload_data  <= data_n;
            busy          <= (state_n == LOAD) || (state_n == GAP);
            done_pulse    <= fin;
            loaded        <= loaded_n;
            load_count    <= cnt_n;
            // Out-of-range indices match no entry and are dropped.
            for (int i = 0; i < NUM_REGS; i++)
                if (cfg_we && cfg_idx == IW'(i)) tbl[i] <= cfg_data;
        end
    end
endmodule

// File: tb/tb_i2c_reg_preload_seq.sv
// tb_i2c_reg_preload_seq: scoreboard bench for i2c_reg_preload_seq, default
// instance plus a GAP_CYCLES=2 / AUTO_START=0 instance.
module tb_i2c_reg_preload_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, hold_a = 1'b0, cfg_we = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [7:0] cfg_data = '0;
    logic       req_b = 1'b0, hold_b = 1'b0, we_b = 1'b0;
    logic [2:0] idx_b = '0;
    logic [7:0] dat_b = '0;

    logic       a_en, a_busy, a_done, a_loaded;
    logic [7:0] a_addr, a_data, a_cnt;
    logic       b_en, b_busy, b_done, b_loaded;
    logic [7:0] b_addr, b_data, b_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ea, eb;

    always #5 clk = ~clk;

    i2c_reg_preload_seq dut (
        .clk(clk), .rst_n(rst_n), .reload_req(req_a), .hold(hold_a),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .preload_en(a_en), .preload_addr(a_addr), .preload_data(a_data),
        .busy(a_busy), .done_pulse(a_done), .loaded(a_loaded), .load_count(a_cnt)
    );

    i2c_reg_preload_seq #(.GAP_CYCLES(2), .AUTO_START(1'b0)) dut_gap (
        .clk(clk), .rst_n(rst_n), .reload_req(req_b), .hold(hold_b),
        .cfg_we(we_b), .cfg_idx(idx_b), .cfg_data(dat_b),
        .preload_en(b_en), .preload_addr(b_addr), .preload_data(b_data),
        .busy(b_busy), .done_pulse(b_done), .loaded(b_loaded), .load_count(b_cnt)
    );

    always @(negedge clk) begin
        if (rst_n && a_en) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_write got %h/%h required no write", a_addr, a_data);
            end else begin
                ea = qa.pop_front();
                if ({a_addr, a_data} !== ea) begin
                    errors++;
                    $display("FAIL a_write got %h/%h required %h/%h", a_addr, a_data, ea[15:8], ea[7:0]);
                end
            end
        end
        if (rst_n && b_en) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_write got %h/%h required no write", b_addr, b_data);
            end else begin
                eb = qb.pop_front();
                if ({b_addr, b_data} !== eb) begin
                    errors++;
                    $display("FAIL b_write got %h/%h required %h/%h", b_addr, b_data, eb[15:8], eb[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] d0, d1, d2, d3);
        qa.push_back({8'd0, d0});
        qa.push_back({8'd1, d1});
        qa.push_back({8'd2, d2});
        qa.push_back({8'd3, d3});
    endtask

    task automatic wait_done(input string nm);
        int i = 0;
        do begin step(); i++; end while (!a_done && i < 40);
        checks++;
        if (!a_done) begin
            errors++;
            $display("FAIL %s done_timeout got 0 required 1", nm);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({a_en, a_addr, a_data, a_busy, a_done, a_loaded, a_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {a_en, a_addr, a_data, a_busy, a_done, a_loaded, a_cnt});
        end
        push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++;
        if ({a_busy, a_en} !== 2'b10) begin
            errors++;
            $display("FAIL auto_start got busy,en=%b required 10", {a_busy, a_en});
        end
        checks++;
        if ({b_busy, b_en} !== 2'b00) begin
            errors++;
            $display("FAIL no_auto_start got busy,en=%b required 00", {b_busy, b_en});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (a_en !== 1'b1) begin
                errors++;
                $display("FAIL auto_burst%0d got en=%b required 1", i, a_en);
            end
        end
        step();
        checks++;
        if ({a_en, a_done, a_loaded, a_cnt, a_busy} !== {1'b0, 1'b1, 1'b1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL auto_done got %h required %h", {a_en, a_done, a_loaded, a_cnt, a_busy}, {1'b0, 1'b1, 1'b1, 8'd1, 1'b0});
        end
        step();
        checks++;
        if (a_done !== 1'b0 || qa.size() != 0) begin
            errors++;
            $display("FAIL auto_tail got done=%b left=%0d required 0/0", a_done, qa.size());
        end
    endtask

    task automatic test_gap_hold();
        int t[4];
        int n = 0;
        int hl = 0;
        qb.push_back({8'd0, 8'hAA});
        qb.push_back({8'd1, 8'hBB});
        qb.push_back({8'd2, 8'hCC});
        qb.push_back({8'd3, 8'hDD});
        req_b = 1'b1;
        step();
        req_b = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            step();
            if (b_en) begin
                t[n] = c;
                n++;
                if (n == 2) hl = 3;
            end
            if (n >= 1 && n <= 3) begin
                checks++;
                if (b_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_busy cycle %0d got %b required 1", c, b_busy);
                end
            end
            hold_b = (hl > 0);
            if (hl > 0) hl--;
        end
        hold_b = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL gap_count got %0d required 4", n);
        end else begin
            checks++;
            if (t[1] - t[0] != 3 || t[2] - t[1] != 6 || t[3] - t[2] != 3) begin
                errors++;
                $display("FAIL gap_spacing got %0d,%0d,%0d required 3,6,3", t[1] - t[0], t[2] - t[1], t[3] - t[2]);
            end
        end
        step();
        checks++;
        if ({b_done, b_cnt, b_busy} !== {1'b1, 8'd1, 1'b0} || qb.size() != 0) begin
            errors++;
            $display("FAIL gap_done got %h left=%0d required %h/0", {b_done, b_cnt, b_busy}, qb.size(), {1'b1, 8'd1, 1'b0});
        end
    endtask

    task automatic test_cfg_reload();
        cfg_we = 1'b1; cfg_idx = 3'd1; cfg_data = 8'h12;
        step();
        cfg_we = 1'b0;
        push4(8'hAA, 8'h12, 8'hCC, 8'hDD);
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        checks++;
        if ({a_loaded, a_busy} !== 2'b01) begin
            errors++;
            $display("FAIL reload_start got loaded,busy=%b required 01", {a_loaded, a_busy});
        end
        wait_done("cfg_reload");
        checks++;
        if ({a_loaded, a_cnt} !== {1'b1, 8'd2} || qa.size() != 0) begin
            errors++;
            $display("FAIL reload_end got %h left=%0d required %h/0", {a_loaded, a_cnt}, qa.size(), {1'b1, 8'd2});
        end
    endtask

    task automatic test_back_to_back();
        push4(8'hAA, 8'h12, 8'hCC, 8'hDD);
        push4(8'hAA, 8'h12, 8'hCC, 8'hDD);
        req_a = 1'b1; step(); req_a = 1'b0; step();
        req_a = 1'b1; step(); req_a = 1'b0; step();
        req_a = 1'b1; step(); req_a = 1'b0;
        wait_done("b2b_first");
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart got busy=%b required 1", a_busy);
        end
        step();
        checks++;
        if (a_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_immediate got en=%b required 1", a_en);
        end
        wait_done("b2b_second");
        repeat (5) step();
        checks++;
        if (a_busy !== 1'b0 || a_cnt !== 8'd4 || qa.size() != 0) begin
            errors++;
            $display("FAIL b2b_single_extra got busy=%b cnt=%0d left=%0d required 0/4/0", a_busy, a_cnt, qa.size());
        end
    endtask

    task automatic test_same_edge_cfg();
        push4(8'hAA, 8'h12, 8'hCC, 8'hDD);
        req_a = 1'b1; step(); req_a = 1'b0;
        step();
        step();
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_data = 8'h77;
        step();
        cfg_we = 1'b0;
        wait_done("same_edge");
        cfg_we = 1'b1; cfg_idx = 3'd5; cfg_data = 8'h55;
        step();
        cfg_we = 1'b0;
        push4(8'hAA, 8'h12, 8'h77, 8'hDD);
        req_a = 1'b1; step(); req_a = 1'b0;
        wait_done("new_value");
        checks++;
        if (a_cnt !== 8'd6 || qa.size() != 0) begin
            errors++;
            $display("FAIL same_edge_end got cnt=%0d left=%0d required 6/0", a_cnt, qa.size());
        end
    endtask

    task automatic test_async_reset();
        qa.push_back({8'd0, 8'hAA});
        req_a = 1'b1; step(); req_a = 1'b0;
        step();
        step();
        checks++;
        if ({a_en, a_addr, a_data} !== {1'b1, 8'd1, 8'h12}) begin
            errors++;
            $display("FAIL abort_idx1 got %h required %h", {a_en, a_addr, a_data}, {1'b1, 8'd1, 8'h12});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_en, a_addr, a_data, a_busy, a_done, a_loaded, a_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL async_reset got %h required 0", {a_en, a_addr, a_data, a_busy, a_done, a_loaded, a_cnt});
        end
        repeat (2) step();
        push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        @(negedge clk) rst_n = 1'b1;
        wait_done("restart");
        checks++;
        if (a_cnt !== 8'd1 || qa.size() != 0) begin
            errors++;
            $display("FAIL restart_end got cnt=%0d left=%0d required 1/0", a_cnt, qa.size());
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 260; k++) begin
            push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
            req_a = 1'b1; step(); req_a = 1'b0;
            wait_done("saturate");
        end
        checks++;
        if (a_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL count_saturate got %h required ff", a_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_gap_hold();
        test_cfg_reload();
        test_back_to_back();
        test_same_edge_cfg();
        test_async_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
